// File: rtl/chocorrol_fetch.sv
// Instruction sequencer for the Chocorrol datapath: host-loaded program memory,
// one word per cycle on instruccion_o with stall back-pressure and HALT detection.
module chocorrol_fetch #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned IW    = 20
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [IW-1:0] wr_data_i,
   output logic          wr_err_o,
   input  logic [AW:0]   prog_len_i,
   input  logic          start_i,
   input  logic          stall_i,
   output logic [IW-1:0] instruccion_o,
   output logic          instr_valid_o,
   input  logic [31:0]   resultado_i,
   output logic [31:0]   last_result_o,
   output logic [AW-1:0] pc_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          halted_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

   localparam int unsigned CW = AW + 1;

   state_e        state_q, state_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] instr_q, instr_d;
   logic          valid_q, valid_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [31:0]   last_q, last_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          halted_q, halted_d;
   logic          wr_err_q, wr_err_d;

   logic [IW-1:0] mem_q [DEPTH];

   logic          wr_ok;
   logic [IW-1:0] word0;
   logic [AW-1:0] pc_inc;
   logic [IW-1:0] next_word;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] len_clamp;

   assign wr_ok     = wr_en_i && (state_q == S_IDLE);
   // A write landing with START at address 0 must be seen by the first fetch.
   assign word0     = (wr_ok && (wr_addr_i == '0)) ? wr_data_i : mem_q[0];
   assign pc_inc    = pc_q + AW'(1);
   assign next_word = mem_q[pc_inc];
   assign cnt_inc   = cnt_q + CW'(1);
   assign len_clamp = (prog_len_i > CW'(DEPTH)) ? CW'(DEPTH) : prog_len_i;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      pc_d     = pc_q;
      last_d   = last_q;
      halted_d = halted_q;
      wr_err_d = wr_en_i && (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               len_d    = len_clamp;
               cnt_d    = '0;
               halted_d = 1'b0;
               if (len_clamp == '0) begin
                  state_d = S_FIN;
               end else if (word0[IW-1 -: 2] == 2'b11) begin
                  state_d  = S_FIN;
                  halted_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  instr_d = word0;
                  pc_d    = '0;
                  valid_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (valid_q && !stall_i) begin
               last_d = resultado_i;
               cnt_d  = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = S_FIN;
                  valid_d = 1'b0;
               end else if (next_word[IW-1 -: 2] == 2'b11) begin
                  state_d  = S_FIN;
                  valid_d  = 1'b0;
                  halted_d = 1'b1;
               end else begin
                  instr_d = next_word;
                  pc_d    = pc_inc;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase

      done_d = (state_d == S_FIN);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         pc_q     <= '0;
         last_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         halted_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         halted_q <= halted_d;
         wr_err_q <= wr_err_d;
      end
   end

   assign instruccion_o = instr_q;
   assign instr_valid_o = valid_q;
   assign pc_o          = pc_q;
   assign last_result_o = last_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign halted_o      = halted_q;
   assign wr_err_o      = wr_err_q;

endmodule

// File: tb/tb_chocorrol_fetch.sv
// Bench for chocorrol_fetch: directed table of runs, stall/reset/write-error
// sequences, and random programs checked against a program-level model.
module tb_chocorrol_fetch;

   logic        clk;
   logic        rst_n;
   logic        wr_en_i;
   logic [3:0]  wr_addr_i;
   logic [19:0] wr_data_i;
   logic        wr_err_o;
   logic [4:0]  prog_len_i;
   logic        start_i;
   logic        stall_i;
   logic [19:0] instruccion_o;
   logic        instr_valid_o;
   logic [31:0] resultado;
   logic [31:0] last_result_o;
   logic [3:0]  pc_o;
   logic        busy_o;
   logic        done_o;
   logic        halted_o;

   chocorrol_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (wr_en_i),
      .wr_addr_i    (wr_addr_i),
      .wr_data_i    (wr_data_i),
      .wr_err_o     (wr_err_o),
      .prog_len_i   (prog_len_i),
      .start_i      (start_i),
      .stall_i      (stall_i),
      .instruccion_o(instruccion_o),
      .instr_valid_o(instr_valid_o),
      .resultado_i  (resultado),
      .last_result_o(last_result_o),
      .pc_o         (pc_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .halted_o     (halted_o)
   );

   localparam logic [19:0] W_AND = {2'b01, 5'd4, 3'b000, 5'd3, 5'd0};
   localparam logic [19:0] W_SUB = {2'b01, 5'd6, 3'b110, 5'd5, 5'd2};
   localparam logic [19:0] W_SLT = {2'b01, 5'd3, 3'b111, 5'd4, 5'd3};
   localparam logic [19:0] W_NOR = {2'b01, 5'd2, 3'b100, 5'd1, 5'd4};
   localparam logic [19:0] W_HLT = 20'b11_00000_000_00000_00000;
   localparam logic [19:0] W_T1  = 20'b01_00001_010_00010_00001;
   localparam logic [31:0] R_NOR = 32'hFFFF_FFFC;

   // Small datapath model: result of a word from its ALUC and operand fields.
   function automatic logic [31:0] dp(input logic [19:0] w);
      logic [31:0] a, b;
      a = 32'(w[17:13]);
      b = 32'(w[9:5]);
      case (w[12:10])
         3'b000:  dp = a & b;
         3'b001:  dp = a | b;
         3'b010:  dp = a + b;
         3'b100:  dp = ~(a | b);
         3'b110:  dp = a - b;
         3'b111:  dp = (a < b) ? 32'd1 : 32'd0;
         default: dp = a ^ b;
      endcase
   endfunction

   assign resultado = dp(instruccion_o);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: counts events per clock edge; the sole writer of these variables.
   int          cyc, done_cnt, stall_cnt, valid_cnt, haltvis, wrerr_cnt, iss_n, t_start, t_done;
   logic [3:0]  iss_pc [4096];
   logic [19:0] iss_w  [4096];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (start_i && !busy_o) t_start <= cyc;
         if (done_o) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
         end
         if (instr_valid_o) begin
            valid_cnt <= valid_cnt + 1;
            if (instruccion_o[19:18] == 2'b11) haltvis <= haltvis + 1;
            if (stall_i) begin
               stall_cnt <= stall_cnt + 1;
            end else begin
               iss_pc[iss_n % 4096] <= pc_o;
               iss_w[iss_n % 4096]  <= instruccion_o;
               iss_n                <= iss_n + 1;
            end
         end
         if (wr_err_o) wrerr_cnt <= wrerr_cnt + 1;
      end
   end

   int          total, bad;
   logic [19:0] mdl_mem [16];
   logic [31:0] cur_last;

   typedef struct {
      logic [4:0]  plen;
      logic [19:0] w2;
      int          n;
      bit          h;
      logic [31:0] last;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " instr"},  64'(instruccion_o), 0);
      chk({nm, " valid"},  64'(instr_valid_o), 0);
      chk({nm, " pc"},     64'(pc_o), 0);
      chk({nm, " last"},   64'(last_result_o), 0);
      chk({nm, " busy"},   64'(busy_o), 0);
      chk({nm, " done"},   64'(done_o), 0);
      chk({nm, " halted"}, 64'(halted_o), 0);
      chk({nm, " wr_err"}, 64'(wr_err_o), 0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [19:0] d);
      @(negedge clk);
      wr_en_i   = 1'b1;
      wr_addr_i = a;
      wr_data_i = d;
      mdl_mem[a] = d;
      @(negedge clk);
      wr_en_i = 1'b0;
   endtask

   // mode 0: no stall, 1: stall 3 cycles while PC=1, 2: random stall.
   task automatic run_case(input string nm, input logic [4:0] plen, input int n_exp,
                           input bit h_exp, input logic [31:0] last_exp, input int mode,
                           input bit wr_busy, input bit fw, input logic [19:0] fw_w);
      int b_done, b_stall, b_valid, b_hv, b_we, b_iss, held, got;
      bit to;
      b_done  = done_cnt;
      b_stall = stall_cnt;
      b_valid = valid_cnt;
      b_hv    = haltvis;
      b_we    = wrerr_cnt;
      b_iss   = iss_n;
      @(negedge clk);
      start_i    = 1'b1;
      prog_len_i = plen;
      if (fw) begin
         wr_en_i    = 1'b1;
         wr_addr_i  = 4'd0;
         wr_data_i  = fw_w;
         mdl_mem[0] = fw_w;
      end
      @(negedge clk);
      start_i = 1'b0;
      wr_en_i = 1'b0;
      held = 0;
      to   = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (!busy_o) begin
            to = 1'b0;
            break;
         end
         wr_en_i = 1'b0;
         if (wr_busy && c == 0) begin
            wr_en_i   = 1'b1;
            wr_addr_i = 4'd3;
            wr_data_i = 20'h01234;
         end
         case (mode)
            1: begin
               if (instr_valid_o && pc_o == 4'd1) begin
                  chk($sformatf("%s hold word c%0d", nm, c), 64'(instruccion_o), 64'(mdl_mem[1]));
                  stall_i = (held < 3);
                  if (held < 3) held++;
               end else begin
                  stall_i = 1'b0;
               end
            end
            2: stall_i = ($urandom_range(0, 9) < 3);
            default: stall_i = 1'b0;
         endcase
         @(negedge clk);
      end
      stall_i = 1'b0;
      wr_en_i = 1'b0;
      if (to) chk({nm, " timeout"}, 1, 0);
      got = iss_n - b_iss;
      chk({nm, " done pulses"}, 64'(done_cnt - b_done), 1);
      chk({nm, " issues"}, 64'(got), 64'(n_exp));
      for (int i = 0; i < n_exp && i < got; i++) begin
         chk($sformatf("%s issue%0d pc/word", nm, i),
             {40'd0, iss_pc[(b_iss + i) % 4096], iss_w[(b_iss + i) % 4096]},
             {40'd0, 4'(i), mdl_mem[i]});
      end
      chk({nm, " last_result"}, 64'(last_result_o), 64'(last_exp));
      chk({nm, " halted"}, 64'(halted_o), 64'(h_exp));
      chk({nm, " latency"}, 64'(t_done - t_start), 64'(n_exp + (stall_cnt - b_stall) + 1));
      chk({nm, " valid cycles"}, 64'(valid_cnt - b_valid), 64'(n_exp + (stall_cnt - b_stall)));
      chk({nm, " halt word shown"}, 64'(haltvis - b_hv), 0);
      chk({nm, " wr_err pulses"}, 64'(wrerr_cnt - b_we), 64'(wr_busy));
      if (mode == 1) chk({nm, " stall cycles"}, 64'(held), 3);
      cur_last = last_exp;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench exceeded time limit");
      $fatal(1);
   end

   initial begin
      int          n, plen_i, lim;
      bit          h;
      logic [31:0] lst;
      bit          found;
      int          b_done;
      logic [1:0]  mc;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      wr_en_i = 1'b0;
      wr_addr_i = '0;
      wr_data_i = '0;
      prog_len_i = '0;
      start_i = 1'b0;
      stall_i = 1'b0;
      cur_last = '0;

      tbl[0] = '{5'd4,  W_SLT, 4,  1'b0, R_NOR};
      tbl[1] = '{5'd1,  W_SLT, 1,  1'b0, 32'd0};
      tbl[2] = '{5'd2,  W_SLT, 2,  1'b0, 32'd1};
      tbl[3] = '{5'd5,  W_HLT, 2,  1'b1, 32'd1};
      tbl[4] = '{5'd2,  W_HLT, 2,  1'b0, 32'd1};
      tbl[5] = '{5'd0,  W_HLT, 0,  1'b0, 32'd1};
      tbl[6] = '{5'd16, W_SLT, 16, 1'b0, 32'd16};
      tbl[7] = '{5'd31, W_SLT, 16, 1'b0, 32'd16};

      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      wr(4'd0, W_AND);
      wr(4'd1, W_SUB);
      wr(4'd2, W_SLT);
      wr(4'd3, W_NOR);
      for (int i = 4; i < 16; i++) wr(4'(i), {2'b00, 5'(i), 3'b010, 5'd1, 5'd0});

      // Single-word run; the word is written in the same cycle as START.
      run_case("single", 5'd1, 1, 1'b0, 32'd3, 0, 1'b0, 1'b1, W_T1);
      wr(4'd0, W_AND);

      for (int k = 0; k < 8; k++) begin
         wr(4'd2, tbl[k].w2);
         run_case($sformatf("tbl%0d", k), tbl[k].plen, tbl[k].n, tbl[k].h, tbl[k].last,
                  0, 1'b0, 1'b0, 20'd0);
      end

      run_case("stall3", 5'd4, 4, 1'b0, R_NOR, 1, 1'b0, 1'b0, 20'd0);
      run_case("wr_busy", 5'd4, 4, 1'b0, R_NOR, 0, 1'b1, 1'b0, 20'd0);
      run_case("mem_kept", 5'd4, 4, 1'b0, R_NOR, 0, 1'b0, 1'b0, 20'd0);
      run_case("halt_at0", 5'd4, 0, 1'b1, cur_last, 0, 1'b0, 1'b1, W_HLT);
      wr(4'd0, W_AND);

      // Asynchronous reset while PC=2 aborts the run with no DONE.
      @(negedge clk);
      start_i    = 1'b1;
      prog_len_i = 5'd4;
      @(negedge clk);
      start_i = 1'b0;
      found   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (instr_valid_o && pc_o == 4'd2) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("rst reached pc2", 64'(found), 1);
      b_done = done_cnt;
      #2 rst_n = 1'b0;
      #1 chk_zero("rst midrun");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst no done", 64'(done_cnt - b_done), 0);
      chk("rst idle", 64'(busy_o), 0);
      run_case("rerun", 5'd4, 4, 1'b0, R_NOR, 0, 1'b0, 1'b0, 20'd0);

      // Random programs against the program-level model.
      for (int k = 0; k < 25; k++) begin
         for (int i = 0; i < 16; i++) begin
            mc = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            wr(4'(i), {mc, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom)});
         end
         plen_i = $urandom_range(0, 31);
         lim = (plen_i > 16) ? 16 : plen_i;
         n = lim;
         h = 1'b0;
         for (int i = 0; i < lim; i++) begin
            if (mdl_mem[i][19:18] == 2'b11) begin
               n = i;
               h = 1'b1;
               break;
            end
         end
         lst = (n > 0) ? dp(mdl_mem[n - 1]) : cur_last;
         run_case($sformatf("rnd%0d", k), 5'(plen_i), n, h, lst, 2, 1'b0, 1'b0, 20'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
